// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer, program counter, instruction
// register and hardware link stack for jump-and-link / return.
// Optional feature macro: PCSEQ_STEP_EN adds a 'step' input; when defined,
// all registered state (FSM, pc, ir, link stack, sticky flags) advances
// only on edges where step=1.
//
// Handshake note: there is no valid/ready pairing here. The decoder's
// IL/PS/push_link are sampled on every advancing edge. IL is honoured only
// in FETCH. PS/push_link are honoured only in EXECUTE.
module pc_sequencer #(
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 16,
  parameter int OFF_W      = 8,
  parameter int LINK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef PCSEQ_STEP_EN
  input  logic               step,
`endif
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               IL,
  input  logic [1:0]         PS,
  input  logic               push_link,
  output logic               state,
  output logic [3:0]         opcode,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    pc,
  output logic               stack_ovf,
  output logic               stack_unf
);

  localparam int IDX_W = $clog2(LINK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam int EXT_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;
  localparam logic [1:0] PS_RET  = 2'b11;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } seq_state_t;

  seq_state_t             state_q, state_n;
  logic [PC_W-1:0]        pc_n;
  logic [INSTR_W-1:0]     ir_n;
  logic [SP_W-1:0]        sp, sp_n;
  logic                   ovf_n, unf_n;
  logic                   push_en;
  logic                   advance;

  logic [PC_W-1:0]        link_mem [LINK_DEPTH];

  logic [PC_W-1:0]        pc_inc;
  logic [EXT_W-1:0]       off_wide;
  logic [PC_W-1:0]        pc_jump;
  logic [IDX_W-1:0]       push_idx;
  logic [IDX_W-1:0]       top_idx;
  logic                   stack_full;
  logic                   stack_empty;

`ifdef PCSEQ_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign state  = (state_q == EXECUTE);
  assign opcode = ir[INSTR_W-1:INSTR_W-4];

  // Branch offset is two's complement; sign-extend to at least PC_W bits.
  assign off_wide    = EXT_W'($signed(ir[OFF_W-1:0]));
  assign pc_inc      = pc + PC_W'(1);
  assign pc_jump     = pc + off_wide[PC_W-1:0];
  assign push_idx    = sp[IDX_W-1:0];
  assign top_idx     = sp[IDX_W-1:0] - IDX_W'(1);
  assign stack_full  = (sp == SP_W'(LINK_DEPTH));
  assign stack_empty = (sp == '0);

  // State register for the fetch/execute FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_n;
  end

  // Next-state and datapath update decisions for the current phase.
  always_comb begin
    state_n = state_q;
    pc_n    = pc;
    ir_n    = ir;
    sp_n    = sp;
    ovf_n   = stack_ovf;
    unf_n   = stack_unf;
    push_en = 1'b0;
    if (advance) begin
      unique case (state_q)
        FETCH: begin
          state_n = EXECUTE;
          if (IL) ir_n = instr_in;
        end
        EXECUTE: begin
          state_n = FETCH;
          unique case (PS)
            PS_HOLD: pc_n = pc;
            PS_INC:  pc_n = pc_inc;
            PS_REL: begin
              pc_n = pc_jump;
              if (push_link) begin
                if (stack_full) begin
                  ovf_n = 1'b1;
                end else begin
                  push_en = 1'b1;
                  sp_n    = sp + SP_W'(1);
                end
              end
            end
            PS_RET: begin
              if (stack_empty) begin
                pc_n  = pc_inc;
                unf_n = 1'b1;
              end else begin
                pc_n = link_mem[top_idx];
                sp_n = sp - SP_W'(1);
              end
            end
            default: pc_n = pc;
          endcase
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // Architectural registers: pc, ir, stack pointer and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      pc        <= pc_n;
      ir        <= ir_n;
      sp        <= sp_n;
      stack_ovf <= ovf_n;
      stack_unf <= unf_n;
    end
  end

  // Link stack storage; contents need no reset because sp gates every read.
  always_ff @(posedge clk) begin
    if (push_en) link_mem[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        IL;
  logic [1:0]  PS;
  logic        push_link;
  logic        state;
  logic [3:0]  opcode;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic        stack_ovf;
  logic        stack_unf;
`ifdef PCSEQ_STEP_EN
  logic        step;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] cur_pc;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef PCSEQ_STEP_EN
    .step      (step),
`endif
    .instr_in  (instr_in),
    .IL        (IL),
    .PS        (PS),
    .push_link (push_link),
    .state     (state),
    .opcode    (opcode),
    .ir        (ir),
    .pc        (pc),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction. Fetch drives PS=10/push_link=1 (must be ignored);
  // execute drives IL=1 with a different word (must be ignored).
  task automatic run_instr(input string tag, input logic [15:0] instr, input logic il,
                           input logic [1:0] ps, input logic pl,
                           input logic [15:0] exp_ir, input logic [7:0] exp_pc);
    instr_in = instr; IL = il; PS = 2'b10; push_link = 1'b1;
    tick();
    chk({tag, ".f_state"}, 32'(state), 32'd1);
    chk({tag, ".f_pc"}, 32'(pc), 32'(cur_pc));
    chk({tag, ".f_ir"}, 32'(ir), 32'(exp_ir));
    chk({tag, ".f_opc"}, 32'(opcode), 32'(exp_ir[15:12]));
    instr_in = ~instr; IL = 1'b1; PS = ps; push_link = pl;
    tick();
    chk({tag, ".e_state"}, 32'(state), 32'd0);
    chk({tag, ".e_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, ".e_ir"}, 32'(ir), 32'(exp_ir));
    cur_pc = exp_pc;
  endtask

  task automatic chk_flags(input string tag, input logic ovf, input logic unf);
    chk({tag, ".ovf"}, 32'(stack_ovf), 32'(ovf));
    chk({tag, ".unf"}, 32'(stack_unf), 32'(unf));
  endtask

  initial begin
    rst_n = 1'b0; instr_in = '0; IL = 1'b0; PS = 2'b00; push_link = 1'b0;
`ifdef PCSEQ_STEP_EN
    step = 1'b1;
`endif
    cur_pc = 8'h00;
    #2;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.ir", 32'(ir), 32'd0);
    chk_flags("rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic increment run
    run_instr("inc0", 16'h0000, 1'b1, 2'b01, 1'b0, 16'h0000, 8'h01);
    run_instr("inc1", 16'h0000, 1'b1, 2'b01, 1'b0, 16'h0000, 8'h02);

    // Relative jumps: 02+0E=10, 10-4=0C, 0C+5=11
    run_instr("jmp10", 16'h100E, 1'b1, 2'b10, 1'b0, 16'h100E, 8'h10);
    run_instr("jmpneg", 16'h20FC, 1'b1, 2'b10, 1'b0, 16'h20FC, 8'h0C);
    run_instr("jmppos", 16'h2005, 1'b1, 2'b10, 1'b0, 16'h2005, 8'h11);

    // IL=0 keeps ir
    run_instr("il0", 16'hABCD, 1'b0, 2'b01, 1'b0, 16'h2005, 8'h12);

    // Wrap: 12+ED=FF, then FF+1=00; PS=00 holds
    run_instr("toff", 16'h30ED, 1'b1, 2'b10, 1'b0, 16'h30ED, 8'hFF);
    run_instr("wrap", 16'h0000, 1'b1, 2'b01, 1'b0, 16'h0000, 8'h00);
    run_instr("hold", 16'h4000, 1'b1, 2'b00, 1'b0, 16'h4000, 8'h00);

    // Call/return
    run_instr("to20", 16'h5020, 1'b1, 2'b10, 1'b0, 16'h5020, 8'h20);
    run_instr("call", 16'h6010, 1'b1, 2'b10, 1'b1, 16'h6010, 8'h30);
    run_instr("plign", 16'h7000, 1'b1, 2'b01, 1'b1, 16'h7000, 8'h31);
    run_instr("ret", 16'h8000, 1'b1, 2'b11, 1'b0, 16'h8000, 8'h21);
    chk_flags("ret", 1'b0, 1'b0);

    // Fill stack: pushes 22,23,24,25
    run_instr("push1", 16'h9001, 1'b1, 2'b10, 1'b1, 16'h9001, 8'h22);
    run_instr("push2", 16'h9001, 1'b1, 2'b10, 1'b1, 16'h9001, 8'h23);
    run_instr("push3", 16'h9001, 1'b1, 2'b10, 1'b1, 16'h9001, 8'h24);
    run_instr("push4", 16'h901C, 1'b1, 2'b10, 1'b1, 16'h901C, 8'h40);
    chk_flags("full", 1'b0, 1'b0);
    run_instr("push5", 16'h9002, 1'b1, 2'b10, 1'b1, 16'h9002, 8'h42);
    chk_flags("ovf", 1'b1, 1'b0);
    run_instr("pop1", 16'hC000, 1'b1, 2'b11, 1'b0, 16'hC000, 8'h25);
    run_instr("pop2", 16'hC000, 1'b1, 2'b11, 1'b0, 16'hC000, 8'h24);
    run_instr("pop3", 16'hC000, 1'b1, 2'b11, 1'b0, 16'hC000, 8'h23);
    run_instr("pop4", 16'hC000, 1'b1, 2'b11, 1'b0, 16'hC000, 8'h22);
    chk_flags("pop4", 1'b1, 1'b0);
    run_instr("unf", 16'hC000, 1'b1, 2'b11, 1'b0, 16'hC000, 8'h23);
    chk_flags("unf", 1'b1, 1'b1);
    run_instr("sticky", 16'h1000, 1'b1, 2'b01, 1'b0, 16'h1000, 8'h24);
    chk_flags("sticky", 1'b1, 1'b1);

`ifdef PCSEQ_STEP_EN
    // step=0 freezes everything for 3 cycles
    step = 1'b0; instr_in = 16'hFFFF; IL = 1'b1; PS = 2'b01; push_link = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("step.state", 32'(state), 32'd0);
      chk("step.pc", 32'(pc), 32'h24);
      chk("step.ir", 32'(ir), 32'h1000);
    end
    step = 1'b1;
`endif

    // Async reset mid-EXECUTE with a jump pending
    instr_in = 16'h2010; IL = 1'b1; PS = 2'b00; push_link = 1'b0;
    tick();
    chk("mid.state", 32'(state), 32'd1);
    PS = 2'b10; push_link = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.state", 32'(state), 32'd0);
    chk("arst.pc", 32'(pc), 32'd0);
    chk("arst.ir", 32'(ir), 32'd0);
    chk_flags("arst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_pc = 8'h00;
    run_instr("post", 16'h0000, 1'b1, 2'b01, 1'b0, 16'h0000, 8'h01);
    chk_flags("post", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
